// File: rtl/uart_rxctrl_if.sv
// Byte-stream and status bundle between the uart_rx driver, uart_rxctrl and user logic.
// master: driver/user side that pushes bytes and pulls reads; slave: uart_rxctrl.
interface uart_rxctrl_if #(
  parameter int AW = 10
);
  logic [7:0]  driver_rx_data;
  logic        driver_rx_data_valid;
  logic        rx_rd_en;
  logic [7:0]  rx_rd_data;
  logic        rx_rd_valid;
  logic        rx_empty;
  logic        rx_full;
  logic [AW:0] rx_usedw;
  logic        frame_done;
  logic [15:0] frame_len;
  logic        frame_err;
  logic        overflow;

  modport master (
    output driver_rx_data, driver_rx_data_valid, rx_rd_en,
    input  rx_rd_data, rx_rd_valid, rx_empty, rx_full, rx_usedw,
           frame_done, frame_len, frame_err, overflow
  );

  modport slave (
    input  driver_rx_data, driver_rx_data_valid, rx_rd_en,
    output rx_rd_data, rx_rd_valid, rx_empty, rx_full, rx_usedw,
           frame_done, frame_len, frame_err, overflow
  );
endinterface

// File: rtl/uart_rxctrl.sv
// UART RX buffer: circular byte store with registered read port, plus an
// idle-timeout frame delimiter reporting length and drop status per frame.
module uart_rxctrl #(
  parameter int U_DLY = 1,
  parameter int AW    = 10
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       baud_en,
  input  logic [7:0] idle_ticks,
  uart_rxctrl_if.slave bus
);

  // U_DLY is kept for override compatibility only; registers carry no delay.
  if (U_DLY < 0) begin : g_u_dly_chk
    $error("U_DLY must be non-negative");
  end

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, RECV} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   usedw;
  logic [AW:0]   usedw_nxt;
  logic          empty_q;
  logic          full_q;
  logic          wr_acc;
  logic          wr_drop;
  logic          rd_acc;
  logic [7:0]    rd_data_q;
  logic          rd_valid_q;
  logic          overflow_q;

  state_t        state;
  logic [7:0]    idle_cnt;
  logic [15:0]   len_cnt;
  logic          err;
  logic [7:0]    thr;
  logic [8:0]    idle_inc;
  logic          timeout;
  logic          frame_done_q;
  logic [15:0]   frame_len_q;
  logic          frame_err_q;

  always_comb begin
    wr_acc    = bus.driver_rx_data_valid && !full_q;
    wr_drop   = bus.driver_rx_data_valid && full_q;
    rd_acc    = bus.rx_rd_en && !empty_q;
    usedw_nxt = usedw + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    thr       = (idle_ticks == 8'd0) ? 8'd1 : idle_ticks;
    idle_inc  = {1'b0, idle_cnt} + 9'd1;
    timeout   = idle_inc >= {1'b0, thr};
  end

  // Storage has no reset so it can map onto RAM resources.
  always_ff @(posedge clk_sys) begin
    if (wr_acc) mem[wr_ptr] <= bus.driver_rx_data;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      usedw      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_q <= mem[rd_ptr];
      end
      rd_valid_q <= rd_acc;
      usedw      <= usedw_nxt;
      empty_q    <= (usedw_nxt == '0);
      full_q     <= (usedw_nxt == DEPTH_W);
      if (wr_drop) overflow_q <= 1'b1;
    end
  end

  // A byte outranks a coincident baud tick, so timeout only fires on a quiet tick.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state        <= IDLE;
      idle_cnt     <= '0;
      len_cnt      <= '0;
      err          <= 1'b0;
      frame_done_q <= 1'b0;
      frame_len_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.driver_rx_data_valid) begin
            state    <= RECV;
            idle_cnt <= '0;
            err      <= wr_drop;
            len_cnt  <= wr_acc ? 16'd1 : 16'd0;
          end
        end
        RECV: begin
          if (bus.driver_rx_data_valid) begin
            idle_cnt <= '0;
            if (wr_acc && len_cnt != 16'hFFFF) len_cnt <= len_cnt + 16'd1;
            if (wr_drop) err <= 1'b1;
          end else if (baud_en) begin
            if (timeout) begin
              state        <= IDLE;
              idle_cnt     <= '0;
              frame_done_q <= 1'b1;
              frame_len_q  <= len_cnt;
              frame_err_q  <= err;
            end else begin
              idle_cnt <= idle_inc[7:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rx_rd_data  = rd_data_q;
  assign bus.rx_rd_valid = rd_valid_q;
  assign bus.rx_empty    = empty_q;
  assign bus.rx_full     = full_q;
  assign bus.rx_usedw    = usedw;
  assign bus.overflow    = overflow_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_uart_rxctrl.sv
// Directed bench for uart_rxctrl (AW=4): framing, read path, overflow, wrap, reset.
module tb_uart_rxctrl;

  localparam int AW = 4;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       baud_en;
  logic [7:0] idle_ticks;
  int         n_checks = 0;
  int         n_errors = 0;

  uart_rxctrl_if #(.AW(AW)) bus ();

  uart_rxctrl #(.U_DLY(1), .AW(AW)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .baud_en    (baud_en),
    .idle_ticks (idle_ticks),
    .bus        (bus.slave)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.driver_rx_data       = b;
    bus.driver_rx_data_valid = 1'b1;
    cycle();
    bus.driver_rx_data_valid = 1'b0;
  endtask

  task automatic baud();
    baud_en = 1'b1;
    cycle();
    baud_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    baud_en = 1'b0;
    idle_ticks = 8'd10;
    bus.driver_rx_data = '0;
    bus.driver_rx_data_valid = 1'b0;
    bus.rx_rd_en = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    check("rst_empty", 32'(bus.rx_empty), 32'd1);
    check("rst_full", 32'(bus.rx_full), 32'd0);
    check("rst_usedw", 32'(bus.rx_usedw), 32'd0);
    check("rst_rd_valid", 32'(bus.rx_rd_valid), 32'd0);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_frame_len", 32'(bus.frame_len), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);

    // Frame of 5 bytes, 2 ticks apart, then 10 idle ticks.
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h11 + 8'(i));
      if (i < 4) begin
        baud(); cycle(); baud(); cycle();
      end
    end
    for (int i = 0; i < 9; i++) begin
      baud();
      check("f1_no_done_early", 32'(bus.frame_done), 32'd0);
      cycle();
    end
    baud();
    check("f1_done", 32'(bus.frame_done), 32'd1);
    check("f1_len", 32'(bus.frame_len), 32'd5);
    check("f1_err", 32'(bus.frame_err), 32'd0);
    check("f1_usedw", 32'(bus.rx_usedw), 32'd5);
    cycle();
    check("f1_done_pulse", 32'(bus.frame_done), 32'd0);
    check("f1_len_held", 32'(bus.frame_len), 32'd5);

    // Back-to-back reads, then one read on empty.
    bus.rx_rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rd_valid", 32'(bus.rx_rd_valid), 32'd1);
      check("rd_data", 32'(bus.rx_rd_data), 32'h11 + 32'(i));
    end
    check("rd_empty", 32'(bus.rx_empty), 32'd1);
    cycle();
    check("rd_empty_no_valid", 32'(bus.rx_rd_valid), 32'd0);
    bus.rx_rd_en = 1'b0;
    cycle();

    // Overfill: 18 bytes into 16 slots.
    bus.driver_rx_data_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      bus.driver_rx_data = 8'h20 + 8'(i);
      cycle();
      if (i == 14) check("of_not_full_15", 32'(bus.rx_full), 32'd0);
      if (i == 15) begin
        check("of_full_16", 32'(bus.rx_full), 32'd1);
        check("of_usedw_16", 32'(bus.rx_usedw), 32'd16);
        check("of_no_ovf_yet", 32'(bus.overflow), 32'd0);
      end
    end
    bus.driver_rx_data_valid = 1'b0;
    check("of_overflow", 32'(bus.overflow), 32'd1);
    check("of_usedw_hold", 32'(bus.rx_usedw), 32'd16);
    for (int i = 0; i < 9; i++) begin
      baud(); cycle();
    end
    baud();
    check("of_done", 32'(bus.frame_done), 32'd1);
    check("of_len", 32'(bus.frame_len), 32'd16);
    check("of_err", 32'(bus.frame_err), 32'd1);

    // Full with simultaneous write and read: write dropped, read succeeds.
    bus.driver_rx_data = 8'hEE;
    bus.driver_rx_data_valid = 1'b1;
    bus.rx_rd_en = 1'b1;
    cycle();
    check("fw_rd_valid", 32'(bus.rx_rd_valid), 32'd1);
    check("fw_rd_data", 32'(bus.rx_rd_data), 32'h20);
    check("fw_usedw", 32'(bus.rx_usedw), 32'd15);

    // 1-in/1-out streaming across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      bus.driver_rx_data = 8'h40 + 8'(i);
      cycle();
      check("st_data", 32'(bus.rx_rd_data), (i < 15) ? 32'h21 + 32'(i) : 32'h40 + 32'(i - 15));
      check("st_usedw", 32'(bus.rx_usedw), 32'd15);
    end
    bus.driver_rx_data_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      check("dr_data", 32'(bus.rx_rd_data), 32'h40 + 32'(25 + i));
    end
    bus.rx_rd_en = 1'b0;
    check("dr_empty", 32'(bus.rx_empty), 32'd1);

    // idle_ticks=0 acts as 1: the open frame closes on the next tick.
    idle_ticks = 8'd0;
    baud();
    check("z_close_done", 32'(bus.frame_done), 32'd1);
    check("z_close_len", 32'(bus.frame_len), 32'd40);
    check("z_close_err", 32'(bus.frame_err), 32'd1);
    cycle();
    send_byte(8'h77);
    cycle(); cycle();
    check("z_wait", 32'(bus.frame_done), 32'd0);
    baud();
    check("z_done", 32'(bus.frame_done), 32'd1);
    check("z_len", 32'(bus.frame_len), 32'd1);
    check("z_err", 32'(bus.frame_err), 32'd0);

    // Reset mid-frame discards frame and data.
    idle_ticks = 8'd5;
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mr_empty", 32'(bus.rx_empty), 32'd1);
    check("mr_usedw", 32'(bus.rx_usedw), 32'd0);
    check("mr_overflow", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 6; i++) begin
      baud();
      check("mr_no_done", 32'(bus.frame_done), 32'd0);
    end

    // New frame after reset; idle_ticks lowered live below idle_cnt.
    idle_ticks = 8'd10;
    send_byte(8'h99);
    for (int i = 0; i < 4; i++) begin
      baud();
      check("lv_no_done", 32'(bus.frame_done), 32'd0);
    end
    idle_ticks = 8'd2;
    baud();
    check("lv_done", 32'(bus.frame_done), 32'd1);
    check("lv_len", 32'(bus.frame_len), 32'd1);
    check("lv_err", 32'(bus.frame_err), 32'd0);
    bus.rx_rd_en = 1'b1;
    cycle();
    bus.rx_rd_en = 1'b0;
    check("lv_rd_valid", 32'(bus.rx_rd_valid), 32'd1);
    check("lv_rd_data", 32'(bus.rx_rd_data), 32'h99);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
